// File: rtl/fp4_fft_stream_ctrl_pkg.sv
// Shared types for the FP4 FFT streaming front end: FSM states and the 9-bit output beat.
// No logic; latency and backpressure are properties of the users of these types.
package fp4_fft_stream_ctrl_pkg;
    localparam int SAMPLE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_DONE,
        ST_UNLOAD
    } state_t;

    // Sample layout is {re[7:4], im[3:0]}; the controller moves it opaquely.
    typedef struct packed {
        logic                last;
        logic [SAMPLE_W-1:0] dat;
    } beat_t;
endpackage

// File: rtl/fp4_fft_stream_ctrl_if.sv
// Host stream and fp4_fft_top memory-port bundle; master is the controller side.
// Pure wiring: no latency, and backpressure is carried by s_ready/m_ready.
interface fp4_fft_stream_ctrl_if
    import fp4_fft_stream_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) ();
    logic [ADDR_WIDTH-1:0] n_cfg;
    logic                  s_valid;
    logic                  s_ready;
    logic [SAMPLE_W-1:0]   s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [SAMPLE_W-1:0]   m_data;
    logic                  m_last;
    logic                  busy;
    logic                  frame_done;
    logic                  err_timeout;
    logic                  fft_start;
    logic [ADDR_WIDTH-1:0] fft_n_config;
    logic                  fft_done;
    logic                  ext_wr_en;
    logic [ADDR_WIDTH-1:0] ext_wr_addr;
    logic [SAMPLE_W-1:0]   ext_wr_data;
    logic [ADDR_WIDTH-1:0] ext_rd_addr;
    logic [SAMPLE_W-1:0]   ext_rd_data;

    modport master (
        input  n_cfg, s_valid, s_data, m_ready, fft_done, ext_rd_data,
        output s_ready, m_valid, m_data, m_last, busy, frame_done, err_timeout,
               fft_start, fft_n_config, ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr
    );

    modport slave (
        output n_cfg, s_valid, s_data, m_ready, fft_done, ext_rd_data,
        input  s_ready, m_valid, m_data, m_last, busy, frame_done, err_timeout,
               fft_start, fft_n_config, ext_wr_en, ext_wr_addr, ext_wr_data, ext_rd_addr
    );
endinterface

// File: rtl/fp4_fft_stream_ctrl_fifo2.sv
// Two-entry beat FIFO; head is visible the cycle after push, push/pop may coincide.
// No internal backpressure: the caller guarantees it never pushes when full.
module fp4_stream_fifo2
    import fp4_fft_stream_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  beat_t      push_dat_i,
    input  logic       pop_i,
    output beat_t      head_o,
    output logic [1:0] count_o
);
    beat_t      mem_q [2];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= push_dat_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_i) begin
                rptr_q <= ~rptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/fp4_fft_stream_ctrl.sv
// Loads one frame into fp4_fft_top, starts it, and streams the results back out with last.
// Output sustains one beat/cycle; reads are throttled so FIFO plus in-flight never exceeds 2.
module fp4_fft_stream_ctrl
    import fp4_fft_stream_ctrl_pkg::*;
#(
    parameter int MAX_N          = 32,
    parameter int ADDR_WIDTH     = $clog2(MAX_N),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                   clk,
    input logic                   rst,
    fp4_fft_stream_ctrl_if.master bus
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] n_reg_q, n_reg_d;
    logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic                  rd_done_q, rd_done_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  inflight_q, inflight_last_q, frame_done_q;
    logic                  issue, pop, err_timeout;
    logic [2:0]            occ;
    beat_t                 head;
    logic [1:0]            fifo_cnt;

    fp4_stream_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_dat_i ({inflight_last_q, bus.ext_rd_data}),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_cnt)
    );

    assign pop = bus.m_valid & bus.m_ready;
    // Occupancy after this cycle's pop, so a steady stream can issue every cycle.
    assign occ   = {1'b0, fifo_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue = (state_q == ST_UNLOAD) && !rd_done_q && (occ < 3'd2);

    always_comb begin
        state_d     = state_q;
        n_reg_d     = n_reg_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        rd_done_d   = rd_done_q;
        timer_d     = timer_q;
        err_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    n_reg_d  = bus.n_cfg;
                    wr_cnt_d = '0;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.s_valid) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == n_reg_q) state_d = ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (bus.fft_done) begin
                    rd_cnt_d  = '0;
                    rd_done_d = 1'b0;
                    state_d   = ST_UNLOAD;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TIMER_LAST)) begin
                    err_timeout = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == n_reg_q) rd_done_d = 1'b1;
                end
                if (pop && head.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            n_reg_q         <= '0;
            wr_cnt_q        <= '0;
            rd_cnt_q        <= '0;
            rd_done_q       <= 1'b0;
            timer_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_reg_q         <= n_reg_d;
            wr_cnt_q        <= wr_cnt_d;
            rd_cnt_q        <= rd_cnt_d;
            rd_done_q       <= rd_done_d;
            timer_q         <= timer_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && (rd_cnt_q == n_reg_q);
            frame_done_q    <= pop && head.last;
        end
    end

    assign bus.s_ready      = (state_q == ST_LOAD);
    assign bus.ext_wr_en    = (state_q == ST_LOAD) && bus.s_valid;
    assign bus.ext_wr_addr  = wr_cnt_q;
    assign bus.ext_wr_data  = bus.ext_wr_en ? bus.s_data : '0;
    assign bus.ext_rd_addr  = rd_cnt_q;
    assign bus.fft_start    = (state_q == ST_START);
    assign bus.fft_n_config = n_reg_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.err_timeout  = err_timeout;
    assign bus.frame_done   = frame_done_q;
    assign bus.m_valid      = (fifo_cnt != 2'd0);
    assign bus.m_data       = bus.m_valid ? head.dat : '0;
    assign bus.m_last       = bus.m_valid & head.last;
endmodule
